// File: rtl/pulse_synth.sv
// Multi-channel pulse-wave tone generator: per-channel period counter, 8-step duty
// sequencer and decaying envelope, mixed one channel per cycle into a signed sample.
module pulse_synth #(
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 16,
  parameter int VOL_W    = 5,
  parameter int OUT_W    = 24,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [1:0]          wr_addr,
  input  logic [PERIOD_W-1:0] wr_data,
  input  logic                sample_tick,
  output logic [OUT_W-1:0]    sample,
  output logic                sample_valid,
  output logic                overrun,
  output logic [1:0]          mix_state
);
  localparam int ACC_W = VOL_W + 1 + CH_W;
  localparam int SHIFT = OUT_W - ACC_W;

  // Handshake: sample_tick is a bare strobe with no ready; a tick seen outside IDLE
  // is dropped and flagged on overrun. sample_valid is high for exactly one cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nx;

  logic [PERIOD_W-1:0]     period   [NUM_CH];
  logic [PERIOD_W-1:0]     cnt      [NUM_CH];
  logic [VOL_W-1:0]        vol      [NUM_CH];
  logic [2:0]              duty     [NUM_CH];
  logic [2:0]              step     [NUM_CH];
  logic [3:0]              env_rate [NUM_CH];
  logic [3:0]              env_div  [NUM_CH];
  logic                    env_en   [NUM_CH];
  logic                    ch_en    [NUM_CH];
  logic                    sel      [NUM_CH];
  logic                    env_hit  [NUM_CH];
  logic signed [ACC_W-1:0] contrib  [NUM_CH];
  logic signed [ACC_W-1:0] snap     [NUM_CH];
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic [CH_W-1:0]         idx;
  logic                    wr_ok;
  logic                    last;

  assign wr_ok   = wr_en && (int'(wr_ch) < NUM_CH);
  assign acc_sum = acc + snap[idx];
  assign last    = (idx == CH_W'(NUM_CH - 1));

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      sel[c]     = wr_ok && (wr_ch == CH_W'(c));
      env_hit[c] = ({1'b0, env_div[c]} + 5'd1) >=
                   {1'b0, ((env_rate[c] == 4'd0) ? 4'd1 : env_rate[c])};
      contrib[c] = '0;
      if (ch_en[c] && period[c] != '0) begin
        if (step[c] <= duty[c]) contrib[c] = $signed(ACC_W'(vol[c]));
        else                    contrib[c] = -$signed(ACC_W'(vol[c]));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        period[c]   <= '0;
        cnt[c]      <= PERIOD_W'(1);
        vol[c]      <= '0;
        duty[c]     <= '0;
        step[c]     <= '0;
        env_rate[c] <= '0;
        env_div[c]  <= '0;
        env_en[c]   <= 1'b0;
        ch_en[c]    <= 1'b0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (sel[c]) begin
          case (wr_addr)
            2'd0: period[c] <= wr_data;
            2'd2: duty[c]   <= wr_data[2:0];
            2'd3: begin
              env_rate[c] <= wr_data[5:2];
              env_en[c]   <= wr_data[1];
              ch_en[c]    <= wr_data[0];
            end
            default: ;
          endcase
        end
        // The counter always compares against the live period, so a period
        // rewrite shortens or stretches the step already in progress.
        if (period[c] == '0 || !ch_en[c]) begin
          cnt[c]  <= PERIOD_W'(1);
          step[c] <= 3'd0;
        end else if (cnt[c] >= period[c]) begin
          cnt[c]  <= PERIOD_W'(1);
          step[c] <= step[c] + 3'd1;
        end else begin
          cnt[c] <= cnt[c] + PERIOD_W'(1);
        end
        if (sel[c] && wr_addr == 2'd1) begin
          vol[c]     <= wr_data[VOL_W-1:0];
          env_div[c] <= '0;
        end else if (env_en[c] && sample_tick) begin
          if (env_hit[c]) begin
            env_div[c] <= '0;
            if (vol[c] != '0) vol[c] <= vol[c] - VOL_W'(1);
          end else begin
            env_div[c] <= env_div[c] + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sample_tick) state_nx = ACCUM;
      ACCUM:   if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sample_valid = (state == DONE);
    mix_state    = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      idx     <= '0;
      sample  <= '0;
      overrun <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) snap[c] <= '0;
    end else begin
      if (wr_ok && wr_addr == 2'd3) overrun <= 1'b0;
      if (sample_tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (sample_tick) begin
          for (int c = 0; c < NUM_CH; c++) snap[c] <= contrib[c];
          acc <= '0;
          idx <= '0;
        end
        ACCUM: begin
          acc <= acc_sum;
          idx <= idx + CH_W'(1);
          // Registered on the last add so it is already stable while DONE strobes.
          if (last) sample <= OUT_W'(acc_sum) << SHIFT;
        end
        default: ;
      endcase
    end
  end
endmodule
